// File: rtl/p2r_pkg.sv
// rtl/p2r_pkg.sv - shared constants, arctangent table and FSM states for polar_to_rect
package p2r_pkg;

    localparam int XY_W = 18;
    localparam int Z_W  = 16;

    // 0.60725 * 2^16: inverse of the CORDIC gain, applied to mag before rotating
    localparam logic [15:0] K_Q16 = 16'd39797;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROT,
        OUT
    } state_t;

    // atan(2^-i) with 65536 = 2*pi
    function automatic logic [Z_W-1:0] atan_lut(input logic [3:0] i);
        logic [Z_W-1:0] v;
        case (i)
            4'd0:    v = 16'd8192;
            4'd1:    v = 16'd4836;
            4'd2:    v = 16'd2555;
            4'd3:    v = 16'd1297;
            4'd4:    v = 16'd651;
            4'd5:    v = 16'd326;
            4'd6:    v = 16'd163;
            4'd7:    v = 16'd81;
            4'd8:    v = 16'd41;
            4'd9:    v = 16'd20;
            4'd10:   v = 16'd10;
            4'd11:   v = 16'd5;
            4'd12:   v = 16'd3;
            4'd13:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/polar_to_rect_if.sv
// rtl/polar_to_rect_if.sv - request/result bundle for polar_to_rect; o_sat exists only with P2R_SAT_FLAG_EN
interface polar_to_rect_if;

    logic              i_vld;
    logic              i_rdy;
    logic [7:0]        mag;
    logic [9:0]        phase;
    logic              o_vld;
    logic signed [7:0] a;
    logic signed [7:0] b;
`ifdef P2R_SAT_FLAG_EN
    logic              o_sat;
`endif

    modport master (
        output i_vld, mag, phase,
`ifdef P2R_SAT_FLAG_EN
        input  o_sat,
`endif
        input  i_rdy, o_vld, a, b
    );

    modport slave (
        input  i_vld, mag, phase,
`ifdef P2R_SAT_FLAG_EN
        output o_sat,
`endif
        output i_rdy, o_vld, a, b
    );

endinterface

// File: rtl/p2r_round_sat.sv
// rtl/p2r_round_sat.sv - Q8.8 round half away from zero, optional negate, clip to signed 8 bits
module p2r_round_sat
    import p2r_pkg::*;
(
    input  logic signed [XY_W-1:0] val,
    input  logic                   neg,
    output logic signed [7:0]      q,
    output logic                   clip
);

    logic signed [XY_W-1:0] biased;
    logic signed [XY_W-1:0] whole;
    logic signed [XY_W-1:0] mapped;

    // bias 127 on negatives so the floor of the shift lands away from zero at .5
    assign biased = val + (val[XY_W-1] ? 18'sd127 : 18'sd128);
    assign whole  = biased >>> 8;
    assign mapped = neg ? -whole : whole;

    always_comb begin
        q    = mapped[7:0];
        clip = 1'b0;
        if (mapped > 18'sd127) begin
            q    = 8'sd127;
            clip = 1'b1;
        end else if (mapped < -18'sd128) begin
            q    = -8'sd128;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/polar_to_rect.sv
// rtl/polar_to_rect.sv - iterative rotation-mode CORDIC, (mag, phase) -> (a, b); P2R_SAT_FLAG_EN adds o_sat
module polar_to_rect
    import p2r_pkg::*;
#(
    parameter int ITER = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    polar_to_rect_if.slave bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             mag_q;
    logic [9:0]             phase_q;
    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic signed [Z_W-1:0]  z;
    logic [3:0]             cnt;

    logic signed [XY_W-1:0] x0;
    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  ang;
    logic [1:0]             quad;
    logic signed [XY_W-1:0] a_val;
    logic signed [XY_W-1:0] b_val;
    logic signed [7:0]      a_nxt;
    logic signed [7:0]      b_nxt;
    logic                   a_clip;
    logic                   b_clip;

    assign bus.i_rdy = (state == IDLE);

    assign x0   = XY_W'((32'(mag_q) * 32'(K_Q16)) >> 8);
    assign x_sh = x >>> cnt;
    assign y_sh = y >>> cnt;
    assign ang  = $signed(atan_lut(cnt));
    assign quad = phase_q[9:8];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_vld) state_nxt = INIT;
            INIT:    state_nxt = ROT;
            ROT:     if (cnt == 4'(ITER - 1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Residual quarter-turn is 256 phase counts; one count is 64 units of z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mag_q   <= '0;
            phase_q <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.i_vld) begin
                        mag_q   <= bus.mag;
                        phase_q <= bus.phase;
                    end
                end
                INIT: begin
                    x   <= x0;
                    y   <= '0;
                    z   <= {2'b00, phase_q[7:0], 6'b000000};
                    cnt <= '0;
                end
                ROT: begin
                    if (!z[Z_W-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - ang;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + ang;
                    end
                    cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Quadrant map: q1 -> (-y, x), q2 -> (-x, -y), q3 -> (y, -x)
    assign a_val = quad[0] ? y : x;
    assign b_val = quad[0] ? x : y;

    p2r_round_sat u_round_a (
        .val  (a_val),
        .neg  ((quad == 2'd1) || (quad == 2'd2)),
        .q    (a_nxt),
        .clip (a_clip)
    );

    p2r_round_sat u_round_b (
        .val  (b_val),
        .neg  (quad[1]),
        .q    (b_nxt),
        .clip (b_clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_vld <= 1'b0;
            bus.a     <= '0;
            bus.b     <= '0;
`ifdef P2R_SAT_FLAG_EN
            bus.o_sat <= 1'b0;
`endif
        end else begin
            bus.o_vld <= (state == OUT);
            if (state == OUT) begin
                bus.a <= a_nxt;
                bus.b <= b_nxt;
`ifdef P2R_SAT_FLAG_EN
                bus.o_sat <= a_clip | b_clip;
`endif
            end
        end
    end

`ifndef P2R_SAT_FLAG_EN
    logic sat_unused;
    assign sat_unused = a_clip | b_clip;
`endif

endmodule

// File: tb/tb_polar_to_rect.sv
// tb/tb_polar_to_rect.sv - directed and random checks of polar_to_rect against a trig model; o_sat checked with P2R_SAT_FLAG_EN
module tb_polar_to_rect;

    localparam int ITER = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    polar_to_rect_if bus ();

    polar_to_rect #(.ITER(ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int m;
        int p;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_tot   = 0;
    int   vld_cnt = 0;
`ifdef P2R_SAT_FLAG_EN
    int   rsat;
`endif

    int ax_p[4] = '{0, 256, 512, 768};
    int ax_a[4] = '{100, 0, -100, 0};
    int ax_b[4] = '{0, 100, 0, -100};
    int bb_m[3] = '{50, 120, 181};
    int bb_p[3] = '{100, 300, 900};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Ideal result: round(mag * trig(theta)) half away from zero, clipped to 8 bits
    function automatic int ideal(input int m, input int p, input bit sine);
        real th;
        real v;
        int  r;
        th = 6.283185307179586 * real'(p) / 1024.0;
        v  = sine ? real'(m) * $sin(th) : real'(m) * $cos(th);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else r = -$rtoi(-v + 0.5);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic bit near(input int act, input int req);
        return (act - req <= 1) && (req - act <= 1);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   ea;
        int   eb;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.o_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_o_vld", 1'b0, 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ea = ideal(e.m, e.p, 1'b0);
                    eb = ideal(e.m, e.p, 1'b1);
                    chk("latency", (cyc - e.t) == ITER + 2, cyc - e.t, ITER + 2);
                    chk("model_a", near(int'(bus.a), ea), int'(bus.a), ea);
                    chk("model_b", near(int'(bus.b), eb), int'(bus.b), eb);
                end
            end
            if (bus.i_vld && bus.i_rdy)
                exp_q.push_back('{int'(bus.mag), int'(bus.phase), cyc + 1});
        end
    end

    task automatic send(input int m, input int p);
        int n;
        n = 0;
        while (!bus.i_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.i_rdy) chk("rdy_timeout", 1'b0, n, 0);
        bus.mag   = 8'(m);
        bus.phase = 10'(p);
        bus.i_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.i_vld = 1'b0;
    endtask

    task automatic wait_res(output int ra, output int rb);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        ra  = 0;
        rb  = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_vld) begin
                got = 1'b1;
                ra  = int'(bus.a);
                rb  = int'(bus.b);
`ifdef P2R_SAT_FLAG_EN
                rsat = int'(bus.o_sat);
`endif
            end
        end
        if (!got) chk("result_timeout", 1'b0, n, ITER + 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ra;
        int rb;
        int v0;
        int n;
        int acc[3];

        bus.i_vld = 1'b0;
        bus.mag   = '0;
        bus.phase = '0;

        repeat (3) @(negedge clk);
        chk("reset_a", bus.a == 0, int'(bus.a), 0);
        chk("reset_b", bus.b == 0, int'(bus.b), 0);
        chk("reset_o_vld", bus.o_vld == 0, int'(bus.o_vld), 0);
        chk("reset_i_rdy", bus.i_rdy == 1, int'(bus.i_rdy), 1);
`ifdef P2R_SAT_FLAG_EN
        chk("reset_o_sat", bus.o_sat == 0, int'(bus.o_sat), 0);
`endif

        chk("model_pin_cos0", ideal(100, 0, 1'b0) == 100, ideal(100, 0, 1'b0), 100);
        chk("model_pin_sin90", ideal(100, 256, 1'b1) == 100, ideal(100, 256, 1'b1), 100);
        chk("model_pin_cos180", ideal(100, 512, 1'b0) == -100, ideal(100, 512, 1'b0), -100);
        chk("model_pin_clip45", ideal(181, 128, 1'b0) == 127, ideal(181, 128, 1'b0), 127);
        chk("model_pin_neg225", ideal(181, 640, 1'b1) == -128, ideal(181, 640, 1'b1), -128);
        chk("model_pin_zero", ideal(0, 300, 1'b1) == 0, ideal(0, 300, 1'b1), 0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send(100, ax_p[i]);
            wait_res(ra, rb);
            chk("axis_a", near(ra, ax_a[i]), ra, ax_a[i]);
            chk("axis_b", near(rb, ax_b[i]), rb, ax_b[i]);
        end

        send(181, 128);
        wait_res(ra, rb);
        chk("corner45_a", ra == 127, ra, 127);
        chk("corner45_b", rb == 127, rb, 127);
`ifdef P2R_SAT_FLAG_EN
        chk("corner45_sat", rsat == 1, rsat, 1);
`endif
        send(181, 640);
        wait_res(ra, rb);
        chk("corner225_a", ra == -128, ra, -128);
        chk("corner225_b", rb == -128, rb, -128);
`ifdef P2R_SAT_FLAG_EN
        chk("corner225_sat", rsat == 0, rsat, 0);
`endif

        for (int p = 0; p < 1024; p++) begin
            send(0, p);
            wait_res(ra, rb);
            chk("zero_mag", ra == 0 && rb == 0, (ra != 0) ? ra : rb, 0);
        end

        v0 = vld_cnt;
        for (int k = 0; k < 3; k++) begin
            bus.mag   = 8'(bb_m[k]);
            bus.phase = 10'(bb_p[k]);
            bus.i_vld = 1'b1;
            n = 0;
            while (!bus.i_rdy && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!bus.i_rdy) chk("b2b_rdy_timeout", 1'b0, n, 0);
            @(posedge clk);
            #1;
            acc[k] = cyc;
        end
        bus.i_vld = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_spacing_01", acc[1] - acc[0] == ITER + 3, acc[1] - acc[0], ITER + 3);
        chk("b2b_spacing_12", acc[2] - acc[1] == ITER + 3, acc[2] - acc[1], ITER + 3);
        chk("b2b_pulses", vld_cnt - v0 == 3, vld_cnt - v0, 3);

        send(150, 200);
        repeat (6) @(posedge clk);
        #1;
        v0    = vld_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_a", bus.a == 0, int'(bus.a), 0);
        chk("abort_b", bus.b == 0, int'(bus.b), 0);
        chk("abort_o_vld", bus.o_vld == 0, int'(bus.o_vld), 0);
        chk("abort_i_rdy", bus.i_rdy == 1, int'(bus.i_rdy), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_o_vld", vld_cnt == v0, vld_cnt - v0, 0);

        for (int k = 0; k < 24; k++) begin
            send(int'($urandom_range(0, 181)), int'($urandom_range(0, 1023)));
            wait_res(ra, rb);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
